// File: rtl/candidate_sampler_pkg.sv
// candidate_sampler_pkg
// Shared types and constants for the candidate sampler stages:
//   - sampler_state_e : run FSM states
//   - CNT_W           : width of the run counters (attempts, tries, accepted)
//   - TAPS_W*         : Galois right-shift LFSR tap masks per supported width
//   - lfsr_taps()     : tap mask lookup for a given LFSR width
//   - lfsr_width_ok() : legality check for the LFSR width parameter
package candidate_sampler_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GEN   = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        FAIL  = 3'd4
    } sampler_state_e;

    localparam logic [63:0] TAPS_W16 = 64'h0000_0000_0000_B400;
    localparam logic [63:0] TAPS_W32 = 64'h0000_0000_8020_0003;
    localparam logic [63:0] TAPS_W64 = 64'hD800_0000_0000_0000;

    // Tap mask for the requested width; unsupported widths yield zero and are
    // rejected at elaboration by the sampler itself.
    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        logic [63:0] taps;
        case (width)
            32'd16:  taps = TAPS_W16;
            32'd32:  taps = TAPS_W32;
            32'd64:  taps = TAPS_W64;
            default: taps = 64'h0000_0000_0000_0000;
        endcase
        return taps;
    endfunction

    function automatic logic lfsr_width_ok(input int unsigned width);
        return (width == 32'd16) || (width == 32'd32) || (width == 32'd64);
    endfunction

endpackage

// File: rtl/candidate_sampler_if.sv
// candidate_sampler_if
// Valid/ready sample stream carrying accepted candidates.
//   sample_data  : FIFO head (W bits)
//   sample_valid : FIFO non-empty
//   sample_ready : consumer accepts the head this cycle
// master = producing sampler, slave = consumer.
interface candidate_sampler_if #(
    parameter int unsigned W = 32
) ();
    logic [W-1:0] sample_data;
    logic         sample_valid;
    logic         sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/sampler_fifo.sv
// sampler_fifo
// Small synchronous FIFO shared by the sampler stages.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_data; honoured when not full, or when full and a
//                pop happens in the same cycle (count unchanged)
//   pop        : drop the head; ignored when empty
//   full/empty : occupancy flags
//   head       : oldest entry
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module sampler_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned    AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sampler_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_s  = (count_r == FULL_CNT);
    assign empty_s = (count_r == {(AW+1){1'b0}});
    assign full    = full_s;
    assign empty   = empty_s;
    assign head    = mem_r[rd_ptr_r];

    // Qualify requests: pop needs data; push may use the slot freed by a pop.
    always_comb begin
        do_pop_s  = pop && !empty_s;
        do_push_s = push && (!full_s || do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/candidate_sampler.sv
// candidate_sampler
// Rejection sampler in front of a generated constraint checker. A Galois LFSR
// proposes candidates on `cand`; the checker answers combinationally on `sat`.
// Accepted candidates are queued and streamed out until num_samples have been
// accepted (done) or MAX_TRIES consecutive rejections occur (fail).
//   clk, rst_n   : clock, asynchronous active-low reset (aborts run, flushes FIFO)
//   start        : begin a run (honoured in IDLE, DONE or FAIL)
//   num_samples  : samples to accept, captured on start
//   cand / sat   : candidate to checker / checker verdict
//   smp          : sample stream (master side of candidate_sampler_if)
//   busy         : run in progress (GEN or CHECK)
//   done / fail  : run result, held until the next start
//   attempts     : candidates checked this run, saturating
// Optional: define CANDIDATE_SAMPLER_DEDUP_EN to reject a satisfied candidate
// equal to the previously accepted one.
module candidate_sampler
    import candidate_sampler_pkg::*;
#(
    parameter int unsigned LFSR_W     = 32,
    parameter logic [63:0] SEED       = 64'h0000_0000_0000_0001,
    parameter int unsigned MAX_TRIES  = 1024,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_samples,
    output logic [LFSR_W-1:0]   cand,
    input  logic                sat,
    candidate_sampler_if.master smp,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [CNT_W-1:0]    attempts
);

    localparam logic [63:0]       TAPS_ALL   = lfsr_taps(LFSR_W);
    localparam logic [LFSR_W-1:0] TAPS       = TAPS_ALL[LFSR_W-1:0];
    localparam logic [LFSR_W-1:0] SEED_TRUNC = SEED[LFSR_W-1:0];
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED_EFF   = (SEED_TRUNC == {LFSR_W{1'b0}}) ?
                                               {{(LFSR_W-1){1'b0}}, 1'b1} : SEED_TRUNC;
    localparam logic [CNT_W-1:0]  MAX_TRIES_C = CNT_W'(MAX_TRIES);

    if (!lfsr_width_ok(LFSR_W)) begin : g_bad_lfsr_w
        $error("candidate_sampler: LFSR_W must be 16, 32 or 64");
    end
    if ((MAX_TRIES < 1) || (MAX_TRIES > 65535)) begin : g_bad_max_tries
        $error("candidate_sampler: MAX_TRIES must be in 1..65535");
    end

    sampler_state_e    state_r, state_nx;
    logic [LFSR_W-1:0] lfsr_r, lfsr_nx;
    logic [LFSR_W-1:0] lfsr_step_s;
    logic [LFSR_W-1:0] cand_r, cand_nx;
    logic [CNT_W-1:0]  attempts_r, attempts_nx;
    logic [CNT_W-1:0]  accepted_r, accepted_nx;
    logic [CNT_W-1:0]  tries_r, tries_nx;
    logic [CNT_W-1:0]  target_r, target_nx;
    logic [CNT_W-1:0]  accepted_inc_s;
    logic [CNT_W-1:0]  tries_inc_s;
    logic              stall_r, stall_nx;
    logic              busy_r, done_r, fail_r;
    logic              push_s;
    logic              pop_s;
    logic              run_start_s;
    logic              dup_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              fifo_can_push_s;
    logic [LFSR_W-1:0] fifo_head_s;

    assign lfsr_step_s     = (lfsr_r >> 1) ^ (lfsr_r[0] ? TAPS : {LFSR_W{1'b0}});
    assign accepted_inc_s  = accepted_r + CNT_W'(1);
    assign tries_inc_s     = tries_r + CNT_W'(1);
    assign pop_s           = !fifo_empty_s && smp.sample_ready;
    // A full FIFO still takes a push when its head leaves in the same cycle.
    assign fifo_can_push_s = !fifo_full_s || pop_s;

    assign cand             = cand_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign fail             = fail_r;
    assign attempts         = attempts_r;
    assign smp.sample_data  = fifo_head_s;
    assign smp.sample_valid = !fifo_empty_s;

`ifdef CANDIDATE_SAMPLER_DEDUP_EN
    logic              dedup_valid_r;
    logic [LFSR_W-1:0] dedup_last_r;

    // Remember the most recently accepted candidate of the current run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dedup_valid_r <= 1'b0;
            dedup_last_r  <= {LFSR_W{1'b0}};
        end else if (run_start_s) begin
            dedup_valid_r <= 1'b0;
        end else if (push_s) begin
            dedup_valid_r <= 1'b1;
            dedup_last_r  <= cand_r;
        end
    end

    assign dup_s = dedup_valid_r && (cand_r == dedup_last_r);
`else
    assign dup_s = 1'b0;
`endif

    // Next-state and datapath decisions of the run FSM.
    always_comb begin
        state_nx    = state_r;
        lfsr_nx     = lfsr_r;
        cand_nx     = cand_r;
        attempts_nx = attempts_r;
        accepted_nx = accepted_r;
        tries_nx    = tries_r;
        target_nx   = target_r;
        stall_nx    = 1'b0;
        push_s      = 1'b0;
        run_start_s = 1'b0;
        case (state_r)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    run_start_s = 1'b1;
                    target_nx   = num_samples;
                    attempts_nx = {CNT_W{1'b0}};
                    accepted_nx = {CNT_W{1'b0}};
                    tries_nx    = {CNT_W{1'b0}};
                    if (num_samples == {CNT_W{1'b0}}) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = GEN;
                    end
                end else begin
                    state_nx = state_r;
                end
            end
            GEN: begin
                lfsr_nx  = lfsr_step_s;
                cand_nx  = lfsr_step_s;
                state_nx = CHECK;
            end
            CHECK: begin
                // Count each candidate once, not once per stalled cycle.
                if (!stall_r && (attempts_r != {CNT_W{1'b1}})) begin
                    attempts_nx = attempts_r + CNT_W'(1);
                end else begin
                    attempts_nx = attempts_r;
                end
                if (sat && !dup_s) begin
                    if (fifo_can_push_s) begin
                        push_s      = 1'b1;
                        accepted_nx = accepted_inc_s;
                        tries_nx    = {CNT_W{1'b0}};
                        if (accepted_inc_s == target_r) begin
                            state_nx = DONE;
                        end else begin
                            state_nx = GEN;
                        end
                    end else begin
                        stall_nx = 1'b1;
                        state_nx = CHECK;
                    end
                end else begin
                    tries_nx = tries_inc_s;
                    if (tries_inc_s == MAX_TRIES_C) begin
                        state_nx = FAIL;
                    end else begin
                        state_nx = GEN;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // FSM state, LFSR, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            lfsr_r     <= SEED_EFF;
            cand_r     <= {LFSR_W{1'b0}};
            attempts_r <= {CNT_W{1'b0}};
            accepted_r <= {CNT_W{1'b0}};
            tries_r    <= {CNT_W{1'b0}};
            target_r   <= {CNT_W{1'b0}};
            stall_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            fail_r     <= 1'b0;
        end else begin
            state_r    <= state_nx;
            lfsr_r     <= lfsr_nx;
            cand_r     <= cand_nx;
            attempts_r <= attempts_nx;
            accepted_r <= accepted_nx;
            tries_r    <= tries_nx;
            target_r   <= target_nx;
            stall_r    <= stall_nx;
            busy_r     <= (state_nx == GEN) || (state_nx == CHECK);
            done_r     <= (state_nx == DONE);
            fail_r     <= (state_nx == FAIL);
        end
    end

    sampler_fifo #(
        .WIDTH (LFSR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (cand_r),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (fifo_head_s)
    );

endmodule

// File: tb/tb_candidate_sampler.sv
// tb_candidate_sampler
// Directed and randomized runs of candidate_sampler with a stub checker
// (sat = candidate has no bits in sat_mask, or never). A behavioural model
// walks the LFSR sequence and applies the acceptance rules to predict the
// emitted samples, attempts count and run outcome.
module tb_candidate_sampler;

    localparam int W    = 32;
    localparam int MAXT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_samples;
    logic [31:0] cand;
    logic        sat;
    logic        busy;
    logic        done;
    logic        fail;
    logic [15:0] attempts;

    logic [31:0] sat_mask;
    logic        sat_never;
    int          ready_mode = 1;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] m_lfsr;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          exp_attempts;
    logic        exp_done;
    logic        exp_fail;

    candidate_sampler_if #(.W(W)) sif ();

    candidate_sampler #(
        .LFSR_W     (W),
        .SEED       (64'h0000_0000_0000_0001),
        .MAX_TRIES  (MAXT),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_samples (num_samples),
        .cand        (cand),
        .sat         (sat),
        .smp         (sif.master),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .attempts    (attempts)
    );

    always #5 clk = ~clk;

    assign sat = !sat_never && ((cand & sat_mask) == 32'h0000_0000);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    // Predict a whole run: candidates in LFSR order, accept satisfied ones,
    // give up after MAXT consecutive rejections.
    task automatic model_run(input int n);
        int          acc;
        int          tries;
        bit          stop;
        logic [31:0] c;
        exp_q.delete();
        exp_attempts = 0;
        exp_done     = 1'b0;
        exp_fail     = 1'b0;
        acc          = 0;
        tries        = 0;
        stop         = 1'b0;
        if (n == 0) exp_done = 1'b1;
        while (n != 0 && !stop) begin
            m_lfsr = m_step(m_lfsr);
            c      = m_lfsr;
            if (exp_attempts < 65535) exp_attempts++;
            if (!sat_never && ((c & sat_mask) == 32'h0000_0000)) begin
                exp_q.push_back(c);
                acc++;
                tries = 0;
                if (acc == n) begin
                    exp_done = 1'b1;
                    stop     = 1'b1;
                end
            end else begin
                tries++;
                if (tries == MAXT) begin
                    exp_fail = 1'b1;
                    stop     = 1'b1;
                end
            end
        end
    endtask

    // Issue start for one cycle; returns at the first negedge after start was taken.
    task automatic launch(input int n);
        got_q.delete();
        model_run(n);
        @(negedge clk);
        start       = 1'b1;
        num_samples = 16'(n);
        @(negedge clk);
        start       = 1'b0;
    endtask

    // Wait (bounded) for the run to end and the FIFO to drain, then compare.
    task automatic finish_check(input string tag);
        int cyc = 0;
        while (!((done || fail) && !sif.sample_valid) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " timeout"}, 64'(cyc < 3000), 64'd1);
        chk({tag, " done"}, 64'(done), 64'(exp_done));
        chk({tag, " fail"}, 64'(fail), 64'(exp_fail));
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " attempts"}, 64'(attempts), 64'(exp_attempts));
        chk({tag, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, " sample"}, 64'(got_q[i]), 64'(exp_q[i]));
        end
    endtask

    // Consumer: choose ready for the coming edge, then log any pop it causes.
    initial begin
        sif.sample_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       sif.sample_ready = 1'b0;
                1:       sif.sample_ready = 1'b1;
                default: sif.sample_ready = 1'($urandom_range(0, 1));
            endcase
            if (sif.sample_valid === 1'b1 && sif.sample_ready === 1'b1) begin
                got_q.push_back(sif.sample_data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic any_v;
        logic [31:0] held;
        rst_n       = 1'b0;
        start       = 1'b0;
        num_samples = 16'd0;
        sat_mask    = 32'h0000_0000;
        sat_never   = 1'b0;
        m_lfsr      = 32'h0000_0001;
        #1;
        chk("rst cand", 64'(cand), 64'd0);
        chk("rst valid", 64'(sif.sample_valid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst fail", 64'(fail), 64'd0);
        chk("rst attempts", 64'(attempts), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Always-satisfied checker, three samples, consumer always ready.
        ready_mode = 1;
        launch(3);
        chk("t1 busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t1 valid early", 64'(sif.sample_valid), 64'd0);
        @(negedge clk);
        chk("t1 first valid", 64'(sif.sample_valid), 64'd1);
        chk("t1 first data", 64'(sif.sample_data), 64'(exp_q[0]));
        repeat (3) @(negedge clk);
        chk("t1 done early", 64'(done), 64'd0);
        @(negedge clk);
        chk("t1 done", 64'(done), 64'd1);
        chk("t1 attempts", 64'(attempts), 64'd3);
        finish_check("t1");

        // Checker accepts candidates with low bits 00.
        sat_mask = 32'h0000_0003;
        launch(5);
        finish_check("t2");
        for (int i = 0; i < got_q.size(); i++) begin
            chk("t2 lowbits", 64'(got_q[i] & 32'h0000_0003), 64'd0);
        end

        // Checker never satisfied: fail after exactly MAXT checks.
        sat_never = 1'b1;
        launch(5);
        any_v = sif.sample_valid;
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            any_v = any_v | sif.sample_valid;
        end
        chk("t3 fail early", 64'(fail), 64'd0);
        @(negedge clk);
        chk("t3 fail", 64'(fail), 64'd1);
        chk("t3 attempts", 64'(attempts), 64'd4);
        chk("t3 no valid", 64'(any_v), 64'd0);
        finish_check("t3");
        sat_never = 1'b0;

        // Zero samples requested: done the next cycle, never busy.
        launch(0);
        chk("t5 done", 64'(done), 64'd1);
        chk("t5 busy", 64'(busy), 64'd0);
        chk("t5 fail", 64'(fail), 64'd0);
        finish_check("t5");

        // Consumer stalled: FIFO fills and the fifth candidate is held.
        sat_mask   = 32'h0000_0000;
        ready_mode = 0;
        launch(6);
        repeat (12) @(negedge clk);
        chk("t4 busy", 64'(busy), 64'd1);
        chk("t4 held cand", 64'(cand), 64'(exp_q[4]));
        chk("t4 attempts", 64'(attempts), 64'd5);
        chk("t4 valid", 64'(sif.sample_valid), 64'd1);
        chk("t4 done", 64'(done), 64'd0);
        held = cand;
        repeat (3) @(negedge clk);
        chk("t4 cand stable", 64'(cand), 64'(held));
        chk("t4 attempts stable", 64'(attempts), 64'd5);
        ready_mode = 1;
        finish_check("t4");

        // Randomized runs with a random consumer.
        ready_mode = 2;
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 2))
                0:       sat_mask = 32'h0000_0000;
                1:       sat_mask = 32'h0000_0001;
                default: sat_mask = 32'h0000_0003;
            endcase
            launch(int'($urandom_range(0, 7)));
            finish_check("rand");
        end

        // Asynchronous reset in the middle of a check.
        sat_mask   = 32'h0000_0000;
        ready_mode = 0;
        launch(6);
        @(negedge clk);
        chk("rst mid busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst mid cand", 64'(cand), 64'd0);
        chk("rst mid valid", 64'(sif.sample_valid), 64'd0);
        chk("rst mid busy", 64'(busy), 64'd0);
        chk("rst mid done", 64'(done), 64'd0);
        chk("rst mid fail", 64'(fail), 64'd0);
        chk("rst mid attempts", 64'(attempts), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_lfsr = 32'h0000_0001;
        ready_mode = 1;
        launch(2);
        finish_check("post rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
